// File: rtl/instr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// instr_sequencer_pkg
//   Shared definitions for the instruction sequencer and its opcode decoder.
//   Holds:
//     - instruction field widths and positions (opcode in the top 5 bits,
//       funct in the bottom 4 bits of the instruction word)
//     - opcode constants (AR, T, HALT)
//     - ALU operation codes (ADD..SRL, plus PASS = 4'b1111)
//     - the sequencer state encoding
//     - the decoder output bundle
// ---------------------------------------------------------------------------
package instr_sequencer_pkg;

  // Field geometry. The opcode sits at IR[IW-1:IW-OPCODE_W].
  // funct sits at IR[FUNCT_W-1:0].
  localparam int OPCODE_W = 5;
  localparam int FUNCT_W  = 4;
  localparam int ALUOP_W  = 4;

  // Opcodes
  localparam logic [OPCODE_W-1:0] OP_AR   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_T    = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11111;

  // ALU operations. For AR instructions the funct field is the ALUop.
  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'b0111;
  // Don't-care / pass-through. Used for T, HALT, illegal and after reset.
  localparam logic [ALUOP_W-1:0] ALU_PASS = 4'b1111;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALTED    = 3'd5
  } state_t;

  // Decoder output bundle
  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               writes;          // instruction writes the register file
    logic               mux_write_reg;   // 0 = R-type dest, 1 = T dest
    logic               mux_write_data;  // 0 = ALU result, 1 = immediate
    logic               is_halt;
    logic               is_illegal;
  } dec_t;

endpackage

// File: rtl/instr_sequencer_opcode_decoder.sv
// ---------------------------------------------------------------------------
// instr_sequencer_opcode_decoder
//   Purely combinational decode of an instruction's opcode and funct fields
//   into the datapath control bundle. The sequencer registers this bundle
//   in its DECODE state.
//
//   Ports:
//     opcode  in   5   instruction opcode field
//     funct   in   4   instruction funct field (ALUop for AR)
//     dec     out  dec_t  {alu_op, writes, mux_write_reg, mux_write_data,
//                          is_halt, is_illegal}
// ---------------------------------------------------------------------------
module instr_sequencer_opcode_decoder
  import instr_sequencer_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  output dec_t                dec
);

  always_comb begin
    // Default: unknown opcode. No write, ALU in pass mode, flagged illegal.
    dec                = '0;
    dec.alu_op         = ALU_PASS;
    dec.is_illegal     = 1'b1;

    unique case (opcode)
      OP_AR: begin
        dec.alu_op         = funct;
        dec.writes         = 1'b1;
        dec.mux_write_reg  = 1'b0;
        dec.mux_write_data = 1'b0;
        dec.is_illegal     = 1'b0;
      end
      OP_T: begin
        dec.alu_op         = ALU_PASS;
        dec.writes         = 1'b1;
        dec.mux_write_reg  = 1'b1;
        dec.mux_write_data = 1'b1;
        dec.is_illegal     = 1'b0;
      end
      OP_HALT: begin
        dec.alu_op         = ALU_PASS;
        dec.is_halt        = 1'b1;
        dec.is_illegal     = 1'b0;
      end
      default: begin
        dec.is_illegal     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle instruction sequencer. Fetches instruction words over a
//   req/ack memory handshake and steps each one through
//   FETCH -> DECODE -> EXECUTE -> WRITEBACK, driving the register-file/ALU
//   datapath controls.
//
//   Handshake (imem): imem_req is high for every cycle spent in FETCH, with
//   imem_addr = pc held stable. The transfer completes in any cycle where
//   imem_req and imem_ack are both high; imem_rdata is captured in that cycle.
//   An ack in any other cycle is ignored. An ack in the first request cycle
//   is legal.
//
//   Ports:
//     CLK           in   1    clock, all state on rising edge
//     RST           in   1    synchronous reset, active-high
//     start         in   1    begin/resume from IDLE or HALTED
//     imem_req      out  1    instruction fetch request
//     imem_addr     out  PCW  fetch address (= pc)
//     imem_ack      in   1    fetch data valid this cycle
//     imem_rdata    in   IW   instruction word
//     ALUop         out  4    ALU operation select
//     regWrite      out  1    register file write enable (WRITEBACK only)
//     muxWriteReg   out  1    write-register select (0 R-type, 1 T)
//     muxWriteData  out  1    write-data select (0 ALU, 1 immediate)
//     pc            out  PCW  program counter
//     busy          out  1    high in FETCH/DECODE/EXECUTE/WRITEBACK
//     halted        out  1    high in HALTED
//     illegal       out  1    sticky unknown-opcode flag
//     state         out  state_t  current FSM state (debug)
// ---------------------------------------------------------------------------
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int             IW       = 32,
  parameter int             PCW      = 8,
  parameter logic [PCW-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  output logic               imem_req,
  output logic [PCW-1:0]     imem_addr,
  input  logic               imem_ack,
  input  logic [IW-1:0]      imem_rdata,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               regWrite,
  output logic               muxWriteReg,
  output logic               muxWriteData,
  output logic [PCW-1:0]     pc,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output state_t             state
);

  logic [IW-1:0] ir;

  // Decode results held from DECODE for use in EXECUTE.
  logic          wr_q;
  logic          ill_q;

  dec_t          dec;

  instr_sequencer_opcode_decoder u_dec (
    .opcode (ir[IW-1 -: OPCODE_W]),
    .funct  (ir[FUNCT_W-1:0]),
    .dec    (dec)
  );

  // The middle of the instruction word is datapath-only (register fields,
  // immediate); the sequencer itself never looks at it.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[IW-OPCODE_W-1:FUNCT_W];

  // Status outputs are pure functions of the state register.
  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign busy      = (state == ST_FETCH)   || (state == ST_DECODE) ||
                     (state == ST_EXECUTE) || (state == ST_WRITEBACK);
  assign halted    = (state == ST_HALTED);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      pc           <= RESET_PC;
      ir           <= '0;
      ALUop        <= ALU_PASS;
      regWrite     <= 1'b0;
      muxWriteReg  <= 1'b0;
      muxWriteData <= 1'b0;
      illegal      <= 1'b0;
      wr_q         <= 1'b0;
      ill_q        <= 1'b0;
    end else begin
      // regWrite is a one-cycle pulse: it is only ever raised on the
      // EXECUTE -> WRITEBACK edge and drops again on the next edge.
      regWrite <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (start) state <= ST_FETCH;
        end

        ST_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            pc    <= pc + PCW'(1);   // wraps naturally at 2^PCW
            state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          // Controls are registered here and then held until the next DECODE,
          // so the ALU sees stable inputs through EXECUTE and WRITEBACK.
          ALUop        <= dec.alu_op;
          muxWriteReg  <= dec.mux_write_reg;
          muxWriteData <= dec.mux_write_data;
          wr_q         <= dec.writes;
          ill_q        <= dec.is_illegal;
          state        <= dec.is_halt ? ST_HALTED : ST_EXECUTE;
        end

        ST_EXECUTE: begin
          // Settle cycle for the ALU. regWrite and illegal are loaded here
          // so that they become visible during WRITEBACK.
          regWrite <= wr_q;
          if (ill_q) illegal <= 1'b1;
          state    <= ST_WRITEBACK;
        end

        ST_WRITEBACK: begin
          state <= ST_FETCH;
        end

        ST_HALTED: begin
          if (start) begin
            pc      <= RESET_PC;
            illegal <= 1'b0;
            state   <= ST_FETCH;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//   Directed, table-driven bench for instr_sequencer. Inputs are driven and
//   outputs sampled on the falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int IW  = 32;
  localparam int PCW = 8;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic               start;
  logic               imem_req;
  logic [PCW-1:0]     imem_addr;
  logic               imem_ack;
  logic [IW-1:0]      imem_rdata;
  logic [3:0]         ALUop;
  logic               regWrite;
  logic               muxWriteReg;
  logic               muxWriteData;
  logic [PCW-1:0]     pc;
  logic               busy;
  logic               halted;
  logic               illegal;
  state_t             state;

  instr_sequencer #(.IW(IW), .PCW(PCW), .RESET_PC('0)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ALUop        (ALUop),
    .regWrite     (regWrite),
    .muxWriteReg  (muxWriteReg),
    .muxWriteData (muxWriteData),
    .pc           (pc),
    .busy         (busy),
    .halted       (halted),
    .illegal      (illegal),
    .state        (state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [PCW-1:0] exp_q[$];   // expected fetch addresses, in order
  logic [PCW-1:0] exp_pc;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},    state,        ST_IDLE);
    check({tag, "_pc"},       pc,           '0);
    check({tag, "_req"},      imem_req,     1'b0);
    check({tag, "_aluop"},    ALUop,        4'b1111);
    check({tag, "_regwrite"}, regWrite,     1'b0);
    check({tag, "_mwr"},      muxWriteReg,  1'b0);
    check({tag, "_mwd"},      muxWriteData, 1'b0);
    check({tag, "_busy"},     busy,         1'b0);
    check({tag, "_halted"},   halted,       1'b0);
    check({tag, "_illegal"},  illegal,      1'b0);
  endtask

  // ---------------- driver ----------------
  // Runs one instruction starting from a falling edge where the DUT is in (or
  // about to enter) FETCH. Returns at the falling edge of the next fetch's
  // first request cycle, or at the first HALTED cycle for HALT.
  task automatic run_instr(input logic [4:0] op, input logic [3:0] funct,
                           input int delay, input logic [3:0] e_alu,
                           input logic e_mwr, input logic e_mwd,
                           input logic e_wr, input logic e_ill, input logic e_halt);
    int n = 0;
    logic [PCW-1:0] a_exp;
    exp_q.push_back(exp_pc);
    while (!imem_req && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("fetch_req_seen", imem_req, 1'b1);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd0, 32'd1);
      a_exp = '0;
    end else begin
      a_exp = exp_q.pop_front();
    end
    // wait states: request and address must hold
    for (int d = 0; d < delay; d++) begin
      check("wait_req", imem_req, 1'b1);
      check("wait_addr", imem_addr, a_exp);
      start = 1'(($urandom_range(0, 1)) & !e_halt);
      @(negedge CLK);
    end
    check("fetch_addr", imem_addr, a_exp);
    check("fetch_state", state, ST_FETCH);
    check("fetch_busy", busy, 1'b1);
    imem_rdata = {op, 23'($urandom), funct};
    imem_ack   = 1'b1;
    start      = 1'(($urandom_range(0, 1)) & !e_halt);
    @(negedge CLK);                                   // DECODE (t+1)
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    exp_pc     = exp_pc + PCW'(1);
    check("dec_state", state, ST_DECODE);
    check("dec_pc", pc, exp_pc);
    check("dec_req", imem_req, 1'b0);
    check("dec_regwrite", regWrite, 1'b0);
    if (e_halt) begin
      start = 1'b0;
      @(negedge CLK);                                 // first HALTED cycle
      check("halt_state", state, ST_HALTED);
      check("halt_halted", halted, 1'b1);
      check("halt_busy", busy, 1'b0);
      check("halt_req", imem_req, 1'b0);
      check("halt_regwrite", regWrite, 1'b0);
      check("halt_aluop", ALUop, e_alu);
      check("halt_illegal", illegal, e_ill);
      return;
    end
    @(negedge CLK);                                   // EXECUTE (t+2)
    check("ex_state", state, ST_EXECUTE);
    check("ex_aluop", ALUop, e_alu);
    check("ex_mwr", muxWriteReg, e_mwr);
    check("ex_mwd", muxWriteData, e_mwd);
    check("ex_regwrite", regWrite, 1'b0);
    @(negedge CLK);                                   // WRITEBACK (t+3)
    start = 1'b0;
    check("wb_state", state, ST_WRITEBACK);
    check("wb_regwrite", regWrite, e_wr);
    check("wb_illegal", illegal, e_ill);
    check("wb_aluop", ALUop, e_alu);
    check("wb_mwr", muxWriteReg, e_mwr);
    check("wb_mwd", muxWriteData, e_mwd);
    @(negedge CLK);                                   // next FETCH (t+4)
    check("next_req", imem_req, 1'b1);
    check("next_addr", imem_addr, exp_pc);
    check("next_regwrite", regWrite, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] op;
    logic [3:0] funct;
    int         delay;
    logic [3:0] e_alu;
    logic       e_mwr;
    logic       e_mwd;
    logic       e_wr;
    logic       e_ill;
    logic       e_halt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // op, funct, delay, alu, mwr, mwd, wr, ill(sticky), halt
    vecs[0] = '{5'b00010, 4'b0001, 0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // AR zero-wait
    vecs[1] = '{5'b01011, 4'b0101, 3, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // T, 3 waits
    vecs[2] = '{5'b00010, 4'b1010, 1, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // AR
    vecs[3] = '{5'b00111, 4'b0011, 0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // illegal
    vecs[4] = '{5'b00010, 4'b0010, 2, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // AR, illegal sticky
    vecs[5] = '{5'b11111, 4'b0000, 0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // HALT at pc=5

    start      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    exp_pc     = '0;

    // reset, with a stray ack present
    RST = 1'b1;
    imem_ack = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_outputs("rst_hold");
    RST = 1'b0;
    imem_rdata = {5'b00010, 23'd0, 4'b0001};
    @(negedge CLK);
    check_reset_outputs("idle_ack_ignored");
    imem_ack = 1'b0;

    // start from IDLE
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("start_state", state, ST_FETCH);
    check("start_req", imem_req, 1'b1);

    // table-driven instructions, ending with HALT at pc=5
    for (int i = 0; i < 6; i++) begin
      check("vec_pc", pc, 32'(i));
      run_instr(vecs[i].op, vecs[i].funct, vecs[i].delay, vecs[i].e_alu,
                vecs[i].e_mwr, vecs[i].e_mwd, vecs[i].e_wr, vecs[i].e_ill,
                vecs[i].e_halt);
    end

    // HALTED holds without start
    @(negedge CLK);
    check("halt_hold", halted, 1'b1);
    check("halt_hold_req", imem_req, 1'b0);
    check("halt_hold_pc", pc, 32'd6);

    // restart: pc back to 0, illegal cleared
    start = 1'b1;
    @(negedge CLK);
    start  = 1'b0;
    exp_pc = '0;
    check("restart_state", state, ST_FETCH);
    check("restart_pc", pc, 32'd0);
    check("restart_addr", imem_addr, 32'd0);
    check("restart_illegal", illegal, 1'b0);
    check("restart_halted", halted, 1'b0);

    // walk pc all the way round: the fetch at 255 must wrap to 0
    for (int i = 0; i < 256; i++) begin
      run_instr(5'b00010, 4'(i), 0, 4'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("wrap_pc", pc, 32'd0);
    check("wrap_addr", imem_addr, 32'd0);

    // set up non-reset values, then reset in the middle of a fetch wait
    run_instr(5'b00010, 4'b0110, 0, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr(5'b10101, 4'b0000, 1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr(5'b01011, 4'b0000, 0, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("pre_rst_pc", pc, 32'd3);
    check("pre_rst_req", imem_req, 1'b1);
    @(negedge CLK);
    check("pre_rst_wait_req", imem_req, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_reset_outputs("mid_fetch_rst");

    // late ack after reset must be ignored
    imem_ack   = 1'b1;
    imem_rdata = {5'b00010, 23'd0, 4'b0011};
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("late_ack_state", state, ST_IDLE);
      check("late_ack_pc", pc, 32'd0);
      check("late_ack_req", imem_req, 1'b0);
    end
    imem_ack = 1'b0;

    // normal operation resumes from address 0
    exp_pc = '0;
    exp_q.delete();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    run_instr(5'b00010, 4'b0100, 2, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("resume_pc", pc, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
